// File: rtl/slc3_mem_ctrl.sv
// SLC-3 memory sequencer: turns the control unit's Mem_OE/Mem_WE strobes into
// timed accesses on an asynchronous 16-bit SRAM. All pad outputs and the read
// return path are registered, and each access ends with a one-cycle Mem_Ready.
module slc3_mem_ctrl #(
   parameter int READ_WAIT  = 2,
   parameter int WRITE_WAIT = 2,
   parameter int ADDR_W     = 20
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Mem_OE,
   input  logic              Mem_WE,
   input  logic [15:0]       MAR,
   input  logic [15:0]       MDR_out,
   output logic [15:0]       Data_to_CPU,
   output logic              Mem_Ready,
   output logic [ADDR_W-1:0] SRAM_ADDR,
   output logic              SRAM_CE_N,
   output logic              SRAM_OE_N,
   output logic              SRAM_WE_N,
   output logic              SRAM_UB_N,
   output logic              SRAM_LB_N,
   input  logic [15:0]       SRAM_Din,
   output logic [15:0]       SRAM_Dout,
   output logic              SRAM_Dout_EN
);

   localparam int MAX_WAIT = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
   localparam int CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
   localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_WAIT - 1);
   localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WRITE_WAIT - 1);

   typedef enum logic [2:0] {
      IDLE, RD_WAIT, WR_SETUP, WR_PULSE, WR_HOLD, DONE
   } state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic             accept, accept_wr, capture;
   logic             ce_n_nx, oe_n_nx, we_n_nx, den_nx, rdy_nx;

   // Next state, wait counter and next pad strobes. Strobes are decoded from
   // the next state so that, once registered, they line up with the state.
   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      accept    = 1'b0;
      accept_wr = 1'b0;
      capture   = 1'b0;
      case (state)
         IDLE: begin
            cnt_nx = '0;
            if (Mem_WE) begin
               state_nx  = WR_SETUP;
               accept    = 1'b1;
               accept_wr = 1'b1;
            end else if (Mem_OE) begin
               state_nx = RD_WAIT;
               accept   = 1'b1;
            end
         end
         RD_WAIT: begin
            if (cnt == RD_LAST) begin
               state_nx = DONE;
               capture  = 1'b1;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         WR_SETUP: begin
            state_nx = WR_PULSE;
            cnt_nx   = '0;
         end
         WR_PULSE: begin
            if (cnt == WR_LAST) state_nx = WR_HOLD;
            else                cnt_nx   = cnt + 1'b1;
         end
         WR_HOLD: state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase

      ce_n_nx = !(state_nx inside {RD_WAIT, WR_SETUP, WR_PULSE, WR_HOLD});
      oe_n_nx = (state_nx != RD_WAIT);
      we_n_nx = (state_nx != WR_PULSE);
      den_nx  = (state_nx inside {WR_SETUP, WR_PULSE, WR_HOLD});
      rdy_nx  = (state_nx == DONE);
   end

   // State, counter and registered SRAM strobes; reset parks every strobe inactive.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state        <= IDLE;
         cnt          <= '0;
         SRAM_CE_N    <= 1'b1;
         SRAM_OE_N    <= 1'b1;
         SRAM_WE_N    <= 1'b1;
         SRAM_UB_N    <= 1'b1;
         SRAM_LB_N    <= 1'b1;
         SRAM_Dout_EN <= 1'b0;
         Mem_Ready    <= 1'b0;
      end else begin
         state        <= state_nx;
         cnt          <= cnt_nx;
         SRAM_CE_N    <= ce_n_nx;
         SRAM_OE_N    <= oe_n_nx;
         SRAM_WE_N    <= we_n_nx;
         SRAM_UB_N    <= ce_n_nx;
         SRAM_LB_N    <= ce_n_nx;
         SRAM_Dout_EN <= den_nx;
         Mem_Ready    <= rdy_nx;
      end
   end

   // Address/write data latch at acceptance; read data captured at the end of the OE window.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         SRAM_ADDR   <= '0;
         SRAM_Dout   <= '0;
         Data_to_CPU <= '0;
      end else begin
         if (accept)    SRAM_ADDR   <= ADDR_W'(MAR);
         if (accept_wr) SRAM_Dout   <= MDR_out;
         if (capture)   Data_to_CPU <= SRAM_Din;
      end
   end

endmodule

// File: tb/tb_slc3_mem_ctrl.sv
// Bench for slc3_mem_ctrl: asynchronous SRAM pad model, directed vector table,
// hand-written reset/back-to-back sequences and a randomized phase checked
// against a cycle-budget/memory reference model.
module tb_slc3_mem_ctrl;

   localparam int RW  = 2;
   localparam int WW  = 2;
   localparam int AW  = 20;
   localparam int LEN = ((RW > WW) ? RW : WW) + 8;

   logic          Clk, Reset, Mem_OE, Mem_WE;
   logic [15:0]   MAR, MDR_out, Data_to_CPU, SRAM_Din, SRAM_Dout;
   logic          Mem_Ready, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, SRAM_Dout_EN;
   logic [AW-1:0] SRAM_ADDR;

   int checks = 0;
   int errors = 0;

   slc3_mem_ctrl #(.READ_WAIT(RW), .WRITE_WAIT(WW), .ADDR_W(AW)) dut (
      .Clk(Clk), .Reset(Reset), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
      .MAR(MAR), .MDR_out(MDR_out), .Data_to_CPU(Data_to_CPU), .Mem_Ready(Mem_Ready),
      .SRAM_ADDR(SRAM_ADDR), .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N),
      .SRAM_WE_N(SRAM_WE_N), .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N),
      .SRAM_Din(SRAM_Din), .SRAM_Dout(SRAM_Dout), .SRAM_Dout_EN(SRAM_Dout_EN)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Power-on contents of the SRAM for locations never written.
   function automatic logic [15:0] init_val(input logic [15:0] a);
      logic [31:0] t;
      t = (32'(a) * 32'h9E37) ^ 32'h0000C3A5;
      return t[15:0];
   endfunction

   // SRAM pad model: asynchronous read while CE_N/OE_N low, write while WE_N low.
   logic [15:0] sram     [0:65535];
   bit          wr_valid [0:65535];
   logic [15:0] pad_a;
   assign pad_a = SRAM_ADDR[15:0];

   always @(posedge Clk) begin
      if (!SRAM_CE_N && !SRAM_WE_N && SRAM_Dout_EN) begin
         sram[pad_a]     <= SRAM_Dout;
         wr_valid[pad_a] <= 1'b1;
      end
   end

   always_comb begin
      SRAM_Din = 16'h0000;
      if (!SRAM_CE_N && !SRAM_OE_N)
         SRAM_Din = wr_valid[pad_a] ? sram[pad_a] : init_val(pad_a);
   end

   // Reference model: what the CPU should see.
   logic [15:0] model_mem [int];
   logic [15:0] model_data;

   function automatic logic [15:0] model_read(input logic [15:0] a);
      return model_mem.exists(int'(a)) ? model_mem[int'(a)] : init_val(a);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // One access from the control unit. mode 0: hold request until Mem_Ready;
   // mode 1: drop request in cycle 1; mode 2: change MAR/MDR_out in cycle 1.
   task automatic run_access(input logic oe, input logic we, input logic [15:0] mar,
                             input logic [15:0] mdr, input int mode,
                             input int exp_ready, input logic [15:0] exp_data);
      logic [31:0] rdy_m, oe_m, we_m, den_m, ce_m, ub_m, lb_m;
      logic [31:0] e_oe, e_we, e_den, e_ce;
      logic        addr_bad, dout_bad, conflict;
      logic [15:0] rd_data;
      rdy_m = '0; oe_m = '0; we_m = '0; den_m = '0; ce_m = '0; ub_m = '0; lb_m = '0;
      e_oe = '0; e_we = '0; e_den = '0; e_ce = '0;
      addr_bad = 1'b0; dout_bad = 1'b0; conflict = 1'b0; rd_data = '0;
      for (int c = 1; c <= LEN; c++) begin
         if (we) begin
            if (c >= 2 && c <= WW + 1) e_we[c] = 1'b1;
            if (c <= WW + 2) begin e_den[c] = 1'b1; e_ce[c] = 1'b1; end
         end else if (c <= RW) begin
            e_oe[c] = 1'b1; e_ce[c] = 1'b1;
         end
      end
      @(negedge Clk);
      Mem_OE = oe; Mem_WE = we; MAR = mar; MDR_out = mdr;
      for (int c = 1; c <= LEN; c++) begin
         @(negedge Clk);
         if (!SRAM_OE_N)   oe_m[c]  = 1'b1;
         if (!SRAM_WE_N)   we_m[c]  = 1'b1;
         if (SRAM_Dout_EN) den_m[c] = 1'b1;
         if (!SRAM_CE_N)   ce_m[c]  = 1'b1;
         if (!SRAM_UB_N)   ub_m[c]  = 1'b1;
         if (!SRAM_LB_N)   lb_m[c]  = 1'b1;
         if (!SRAM_CE_N && SRAM_ADDR !== AW'(mar)) addr_bad = 1'b1;
         if (SRAM_Dout_EN && SRAM_Dout !== mdr)    dout_bad = 1'b1;
         if (SRAM_Dout_EN && !SRAM_OE_N)           conflict = 1'b1;
         if (Mem_Ready) begin
            rdy_m[c] = 1'b1;
            rd_data  = Data_to_CPU;
            Mem_OE = 1'b0; Mem_WE = 1'b0;
         end
         if (c == 1 && mode == 1) begin Mem_OE = 1'b0; Mem_WE = 1'b0; end
         if (c == 1 && mode == 2) begin MAR = mar + 16'd1; MDR_out = ~mdr; end
      end
      check("ready_pulse", rdy_m, 32'd1 << exp_ready);
      check("oe_n_window", oe_m, e_oe);
      check("we_n_window", we_m, e_we);
      check("dout_en_window", den_m, e_den);
      check("ce_n_window", ce_m, e_ce);
      check("ub_lb_window", {ub_m[15:0], lb_m[15:0]}, {e_ce[15:0], e_ce[15:0]});
      check("addr_stable", 32'(addr_bad), 32'd0);
      check("dout_stable", 32'(dout_bad), 32'd0);
      check("oe_dout_overlap", 32'(conflict), 32'd0);
      if (!we) check("read_data_at_ready", 32'(rd_data), 32'(exp_data));
      check("data_to_cpu", 32'(Data_to_CPU), 32'(exp_data));
      if (we) check("pad_memory", {15'd0, wr_valid[mar], sram[mar]}, {15'd0, 1'b1, mdr});
   endtask

   typedef struct {
      logic        oe;
      logic        we;
      logic [15:0] mar;
      logic [15:0] mdr;
      int          mode;
      int          exp_ready;
      logic [15:0] exp_data;
   } vec_t;

   vec_t vecs [9];

   initial begin
      logic [31:0] rdy_m, oe_m, e_rdy, e_oe;
      logic [15:0] d1, d2, r_mar, r_mdr, r_exp;
      logic        bad;
      int          npulse, kind, r_mode, r_ready;

      vecs[0] = '{1'b0, 1'b1, 16'h3000, 16'hBEEF, 0, WW + 3, 16'h0000};
      vecs[1] = '{1'b1, 1'b0, 16'h3000, 16'h0000, 0, RW + 1, 16'hBEEF};
      vecs[2] = '{1'b0, 1'b1, 16'h0010, 16'h1234, 0, WW + 3, 16'hBEEF};
      vecs[3] = '{1'b1, 1'b1, 16'h0010, 16'h5678, 0, WW + 3, 16'hBEEF};
      vecs[4] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 0, RW + 1, 16'h5678};
      vecs[5] = '{1'b1, 1'b0, 16'h0005, 16'h0000, 2, RW + 1, init_val(16'h0005)};
      vecs[6] = '{1'b1, 1'b0, 16'h0006, 16'h0000, 1, RW + 1, init_val(16'h0006)};
      vecs[7] = '{1'b0, 1'b1, 16'h0020, 16'h4321, 1, WW + 3, init_val(16'h0006)};
      vecs[8] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 0, RW + 1, 16'h4321};

      Reset = 1'b1; Mem_OE = 1'b0; Mem_WE = 1'b0; MAR = 16'h0; MDR_out = 16'h0;
      model_data = 16'h0;
      repeat (3) @(negedge Clk);
      check("reset_strobes",
            {25'd0, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, SRAM_Dout_EN, Mem_Ready},
            {25'd0, 7'b1111100});
      check("reset_data", {16'd0, Data_to_CPU}, 32'd0);
      check("reset_addr_dout", {12'd0, SRAM_ADDR[3:0], SRAM_Dout} | 32'(SRAM_ADDR), 32'd0);
      Reset = 1'b0;

      // Directed table.
      for (int i = 0; i < 9; i++) begin
         run_access(vecs[i].oe, vecs[i].we, vecs[i].mar, vecs[i].mdr, vecs[i].mode,
                    vecs[i].exp_ready, vecs[i].exp_data);
         if (vecs[i].we) model_mem[int'(vecs[i].mar)] = vecs[i].mdr;
         model_data = vecs[i].exp_data;
      end

      // Reset between edges during the write pulse.
      @(negedge Clk);
      Mem_WE = 1'b1; MAR = 16'h7777; MDR_out = 16'hAAAA;
      @(negedge Clk);
      @(negedge Clk);
      check("pre_reset_we_low", 32'(SRAM_WE_N), 32'd0);
      #2 Reset = 1'b1; Mem_WE = 1'b0;
      #1;
      check("async_reset_strobes", {29'd0, SRAM_WE_N, SRAM_CE_N, SRAM_Dout_EN}, {29'd0, 3'b110});
      repeat (2) @(negedge Clk);
      Reset = 1'b0;
      model_data = 16'h0;
      bad = 1'b0;
      repeat (6) begin
         @(negedge Clk);
         if (!SRAM_CE_N || !SRAM_OE_N || !SRAM_WE_N || SRAM_Dout_EN || Mem_Ready) bad = 1'b1;
      end
      check("idle_after_reset", 32'(bad), 32'd0);
      check("aborted_write_no_store", 32'(wr_valid[16'h7777]), 32'd0);
      check("data_cleared_by_reset", 32'(Data_to_CPU), 32'd0);

      // Back-to-back reads with the request held through DONE.
      rdy_m = '0; oe_m = '0; npulse = 0; d1 = '0; d2 = '0;
      e_rdy = (32'd1 << (RW + 1)) | (32'd1 << (2 * RW + 3));
      e_oe  = '0;
      for (int c = 1; c <= RW; c++) begin e_oe[c] = 1'b1; e_oe[c + RW + 2] = 1'b1; end
      @(negedge Clk);
      Mem_OE = 1'b1; MAR = 16'h0001;
      for (int c = 1; c <= 2 * RW + 6; c++) begin
         @(negedge Clk);
         if (!SRAM_OE_N) oe_m[c] = 1'b1;
         if (Mem_Ready) begin
            rdy_m[c] = 1'b1;
            npulse++;
            if (npulse == 1) begin d1 = Data_to_CPU; MAR = 16'h0002; end
            else begin d2 = Data_to_CPU; Mem_OE = 1'b0; end
         end
      end
      Mem_OE = 1'b0;
      check("b2b_ready_pulses", rdy_m, e_rdy);
      check("b2b_oe_windows", oe_m, e_oe);
      check("b2b_first_data", 32'(d1), 32'(model_read(16'h0001)));
      check("b2b_second_data", 32'(d2), 32'(model_read(16'h0002)));
      model_data = model_read(16'h0002);

      // Randomized accesses against the reference model.
      for (int i = 0; i < 40; i++) begin
         kind   = int'($urandom_range(0, 2));
         r_mar  = 16'h0100 + 16'($urandom_range(0, 15));
         r_mdr  = 16'($urandom);
         r_mode = int'($urandom_range(0, 2));
         if (kind == 0) begin
            model_data = model_read(r_mar);
            r_ready    = RW + 1;
         end else begin
            model_mem[int'(r_mar)] = r_mdr;
            r_ready    = WW + 3;
         end
         r_exp = model_data;
         run_access(kind != 1, kind != 0, r_mar, r_mdr, r_mode, r_ready, r_exp);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/slc3_mem_ctrl.md
Name: slc3_mem_ctrl

Overview:
- Sequencer between the SLC-3 control unit's memory strobes (Mem_OE/Mem_WE, active high) and the external asynchronous 16-bit SRAM.
- Replaces fixed two-state wait sequences with a parameterised wait count and a Mem_Ready completion pulse; the control unit holds its read/write state until Mem_Ready.
- Registers all SRAM control outputs and the read-data return path.

Parameters:
READ_WAIT, 2, cycles OE_N held low before read data is captured (>=1)
WRITE_WAIT, 2, cycles WE_N held low per write (>=1)
ADDR_W, 20, SRAM address width (>=16)

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
Mem_OE  in  1  read request from control unit
Mem_WE  in  1  write request from control unit
MAR  in  16  access address
MDR_out  in  16  write data
Data_to_CPU  out  16  registered read data
Mem_Ready  out  1  one-cycle completion pulse
SRAM_ADDR  out  ADDR_W  SRAM address, {zeros, MAR}
SRAM_CE_N  out  1  chip enable, active low
SRAM_OE_N  out  1  output enable, active low
SRAM_WE_N  out  1  write enable, active low
SRAM_UB_N  out  1  upper byte enable, active low
SRAM_LB_N  out  1  lower byte enable, active low
SRAM_Din  in  16  data from SRAM pad
SRAM_Dout  out  16  data to SRAM pad
SRAM_Dout_EN  out  1  pad tristate enable, 1 = drive

Behaviour:
- Clock and reset: one clock, Clk. Reset is asynchronous and active-high.
- Reset values (applied immediately, not at the next edge):
  - state IDLE; CE_N, OE_N, WE_N, UB_N, LB_N = 1
  - Dout_EN = 0, Mem_Ready = 0
  - Data_to_CPU = 0, SRAM_ADDR = 0, SRAM_Dout = 0
- Outputs: all outputs registered; no combinational path from Mem_OE/Mem_WE to any SRAM pin.
- FSM states: IDLE, RD_WAIT, WR_SETUP, WR_PULSE, WR_HOLD, DONE. Wait counter is sized to max(READ_WAIT, WRITE_WAIT).
- IDLE:
  - Mem_WE=1: latch MAR/MDR_out, go to WR_SETUP. Write wins if Mem_OE and Mem_WE are both high.
  - Else Mem_OE=1: latch MAR, go to RD_WAIT.
  - Else stay in IDLE.
- Read timing (cycle 0 = IDLE cycle in which the request is sampled):
  - Cycles 1..READ_WAIT: CE_N = OE_N = UB_N = LB_N = 0.
  - On the edge ending cycle READ_WAIT, SRAM_Din is captured into Data_to_CPU.
  - Cycle READ_WAIT+1 is DONE: Mem_Ready = 1, OE_N = CE_N = 1.
  - Data_to_CPU holds until the next read capture; writes never change it.
- Write timing:
  - WR_SETUP, 1 cycle: CE_N = 0, Dout_EN = 1, WE_N = 1.
  - WR_PULSE, WRITE_WAIT cycles: WE_N = 0.
  - WR_HOLD, 1 cycle: WE_N = 1, data still driven.
  - DONE: Dout_EN = 0, CE_N = 1, Mem_Ready = 1. Mem_Ready occurs in cycle WRITE_WAIT+3.
  - OE_N stays 1 throughout a write. Dout_EN is never 1 while OE_N = 0.
- DONE lasts 1 cycle, then returns to IDLE. A request still high in the following IDLE cycle starts a new access; the control unit must leave its state on Mem_Ready.
- Address and data latch: SRAM_ADDR and SRAM_Dout latch at request acceptance. MAR/MDR_out changes mid-access are ignored.
- Request dropped mid-access: the access completes and Mem_Ready still pulses.
- Reset mid-write: WE_N, CE_N and Dout_EN deassert asynchronously; no further SRAM activity until a new request after Reset falls.
- Mem_Ready is never high for two consecutive cycles.

Test Plan:
- Read, READ_WAIT=2: MAR=0x3000, SRAM model returns 0xBEEF. Required: OE_N low exactly cycles 1-2, Mem_Ready high in cycle 3 only, Data_to_CPU=0xBEEF from cycle 3.
- Write, WRITE_WAIT=2: MAR=0x0010, MDR_out=0x1234. Required: WE_N low exactly 2 cycles; Dout_EN=1 one cycle before and after the pulse; model memory[0x0010]=0x1234; Mem_Ready in cycle 5.
- Simultaneous Mem_OE=Mem_WE=1: required write sequence only; OE_N never low; Data_to_CPU unchanged.
- Back-to-back requests: read 0x0001 then read 0x0002, request held through DONE. Required: two distinct accesses, two Mem_Ready pulses separated by >=1 low cycle.
- Reset asserted during WR_PULSE, between edges: WE_N=1 and Dout_EN=0 before the next edge. After release with no request: stays IDLE, all SRAM strobes high.
- MAR changed from 0x0005 to 0x0006 during RD_WAIT: SRAM_ADDR stays 0x00005 for the whole access.
